logic_gates: RTL and testbench
==============================

// Module: logic_gates
// PURPOSE
// - Bitwise two-input logic unit: computes AND, OR, NAND, NOR, NOT(a), XOR and XNOR of operands a, b.
// - All results are registered with one-cycle latency, and a valid flag travels alongside them.
// - Leaf datapath block used for gate-level sanity checks and as a small reusable bitwise stage.
// PARAMETERS
// - WIDTH  1  operand/result width in bits (>=1); every operation is applied bit-by-bit
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      a/b carry a valid operand pair this cycle
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - out_valid  out  1      registered results are valid
// - and_gate   out  WIDTH  a & b
// - or_gate    out  WIDTH  a | b
// - nand_gate  out  WIDTH  ~(a & b)
// - nor_gate   out  WIDTH  ~(a | b)
// - not_gate   out  WIDTH  ~a; b has no effect on this output
// - xor_gate   out  WIDTH  a ^ b
// - xnor_gate  out  WIDTH  ~(a ^ b)
// BEHAVIOUR
// - One clock domain, one cycle of latency: results registered at edge N reflect the a/b sampled at edge N.
// - On in_valid=1 at an edge, all seven result registers load, and out_valid<=1 on the next cycle.
// - On in_valid=0 at an edge, the result registers hold their previous values and out_valid<=0.
// - Reset (rst=1, asynchronous):
//   - all seven result outputs clear to 0 immediately, including nand/nor/not/xnor;
//   - out_valid clears to 0;
//   - deasserting reset mid-stream means the first load happens at the first valid edge after release.
// - Results must always be mutually consistent:
//   - nand_gate == ~and_gate;
//   - nor_gate == ~or_gate;
//   - xnor_gate == ~xor_gate.
//   These hold whenever out_valid=1 and also during hold cycles.
// - Equal operands (a==b): xor_gate = 0 and xnor_gate = all ones.
// - No X propagation from the hold path; outputs change only on a clock edge or on reset.
// CONFIGURATION
// - Macro LOGIC_GATES_PARITY_EN.
// - When defined:
//   - adds output port xor_parity (1 bit) = ^(a ^ b), the reduction XOR across all bits;
//   - it is registered with the other results, has the same load/hold behaviour, and resets to 0.
// - When undefined: the port and its register do not exist, and all other behaviour is unchanged.
// STRUCTURE
// - Package logic_gates_pkg holds:
//   - localparam indices for the seven operations (OP_AND=0, OP_OR, OP_NAND, OP_NOR, OP_NOT, OP_XOR, OP_XNOR=6);
//   - NUM_OPS=7.
// - Sub-module logic_gates_core: purely combinational, WIDTH-parameterised, producing the seven results from a and b.
// - logic_gates: the register stage around the core, handling valid, hold and async reset.
// TESTING
// - All four cases use WIDTH=1, in_valid=1, and check outputs one cycle after the inputs are applied.
// - Output order in each case: and, or, nand, nor, not, xor, xnor.
// - a=0,b=0 -> 0,0,1,1,1,0,1.
// - a=0,b=1 -> 0,1,1,0,1,1,0.
// - a=1,b=0 -> 0,1,1,0,0,1,0.
// - a=1,b=1 -> 1,1,0,0,0,0,1.
// - Assert rst mid-run with outputs at 1,1,0,0,0,0,1 -> all outputs and out_valid read 0 before the next edge.
// - Hold case: load a=1,b=0, then drop in_valid and apply a=1,b=1 -> outputs stay 0,1,1,0,0,1,0 and out_valid=0.
// - WIDTH=4 case: a=4'b1100, b=4'b1010 -> results 1000,1110,0111,0001,0011,0110,1001.
//   With LOGIC_GATES_PARITY_EN defined, xor_parity=0.

Source files
------------

// File: rtl/logic_gates_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates_pkg
// Brief    : Shared operation indices and a per-bit gate evaluator for the
//            logic_gates bitwise unit.
// Revision : 1.0 - initial release
// ============================================================================
package logic_gates_pkg;

   // Slot of each operation inside the packed result array
   localparam int OP_AND  = 0;
   localparam int OP_OR   = 1;
   localparam int OP_NAND = 2;
   localparam int OP_NOR  = 3;
   localparam int OP_NOT  = 4;
   localparam int OP_XOR  = 5;
   localparam int OP_XNOR = 6;
   localparam int NUM_OPS = 7;

   // Evaluate one operation on a single bit pair; b is ignored for OP_NOT
   function automatic logic gate_bit(input int op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_NOT:  r = ~a;
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/logic_gates_core.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates_core
// Brief    : Purely combinational bitwise evaluator producing all seven gate
//            results of a and b, packed by operation index.
// Revision : 1.0 - initial release
// ============================================================================
module logic_gates_core
   import logic_gates_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   output logic [NUM_OPS-1:0][WIDTH-1:0]  res
);

   // Every operation is independent per bit, so replicate a single-bit cell
   generate
      for (genvar op = 0; op < NUM_OPS; op++) begin : g_op
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign res[op][i] = gate_bit(op, a[i], b[i]);
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/logic_gates.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates
// Brief    : Registered bitwise logic unit. Computes AND/OR/NAND/NOR/NOT/XOR/
//            XNOR of a and b with one cycle of latency and a valid flag.
//            Results load on in_valid and hold otherwise; async reset clears
//            every output to 0.
//            Optional feature macro: LOGIC_GATES_PARITY_EN adds xor_parity,
//            the registered reduction XOR of a ^ b.
// Revision : 1.0 - initial release
// ============================================================================
module logic_gates
   import logic_gates_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] and_gate,
   output logic [WIDTH-1:0] or_gate,
   output logic [WIDTH-1:0] nand_gate,
   output logic [WIDTH-1:0] nor_gate,
   output logic [WIDTH-1:0] not_gate,
   output logic [WIDTH-1:0] xor_gate,
   output logic [WIDTH-1:0] xnor_gate
`ifdef LOGIC_GATES_PARITY_EN
   ,
   output logic             xor_parity
`endif
);

   logic [NUM_OPS-1:0][WIDTH-1:0] w_core_res;
   logic [NUM_OPS-1:0][WIDTH-1:0] res_d;
   logic [NUM_OPS-1:0][WIDTH-1:0] res_q;
   logic                          valid_d;
   logic                          valid_q;

   logic_gates_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (a),
      .b   (b),
      .res (w_core_res)
   );

   // Load fresh results on a valid pair, otherwise hold the last ones
   always_comb begin
      res_d   = res_q;
      valid_d = in_valid;
      if (in_valid) begin
         res_d = w_core_res;
      end
   end

   // Result and valid registers; reset clears everything, inverting gates included
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

`ifdef LOGIC_GATES_PARITY_EN
   logic parity_d;
   logic parity_q;

   // Parity follows the same load/hold rule as the gate results
   always_comb begin
      parity_d = parity_q;
      if (in_valid) begin
         parity_d = ^w_core_res[OP_XOR];
      end
   end

   // Parity register, cleared by reset alongside the results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign xor_parity = parity_q;
`endif

   assign out_valid = valid_q;
   assign and_gate  = res_q[OP_AND];
   assign or_gate   = res_q[OP_OR];
   assign nand_gate = res_q[OP_NAND];
   assign nor_gate  = res_q[OP_NOR];
   assign not_gate  = res_q[OP_NOT];
   assign xor_gate  = res_q[OP_XOR];
   assign xnor_gate = res_q[OP_XNOR];

endmodule
`default_nettype wire

// File: tb/tb_logic_gates.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gates
// Brief    : Self-checking bench for logic_gates, one instance at WIDTH=1
//            driven from a vector table and one at WIDTH=4 for wide cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_gates;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=1 instance
   logic       v1, a1, b1;
   logic       ov1, and1, or1, nand1, nor1, not1, xor1, xnor1;
   // WIDTH=4 instance
   logic       v4;
   logic [3:0] a4, b4;
   logic       ov4;
   logic [3:0] and4, or4, nand4, nor4, not4, xor4, xnor4;
`ifdef LOGIC_GATES_PARITY_EN
   logic       par1, par4;
`endif

   logic_gates #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
      .out_valid(ov1), .and_gate(and1), .or_gate(or1), .nand_gate(nand1),
      .nor_gate(nor1), .not_gate(not1), .xor_gate(xor1), .xnor_gate(xnor1)
`ifdef LOGIC_GATES_PARITY_EN
      , .xor_parity(par1)
`endif
   );

   logic_gates #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4),
      .out_valid(ov4), .and_gate(and4), .or_gate(or4), .nand_gate(nand4),
      .nor_gate(nor4), .not_gate(not4), .xor_gate(xor4), .xnor_gate(xnor4)
`ifdef LOGIC_GATES_PARITY_EN
      , .xor_parity(par4)
`endif
   );

   // {out_valid, and, or, nand, nor, not, xor, xnor}
   logic [7:0] r1;
   assign r1 = {ov1, and1, or1, nand1, nor1, not1, xor1, xnor1};

   typedef struct {
      logic       a;
      logic       b;
      logic [6:0] exp;
   } vec_t;

   vec_t vt[4];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wide-instance check: seven results in and..xnor order plus out_valid
   task automatic chk4(input string name, input logic ov,
                       input logic [3:0] e_and, input logic [3:0] e_or,
                       input logic [3:0] e_nand, input logic [3:0] e_nor,
                       input logic [3:0] e_not, input logic [3:0] e_xor,
                       input logic [3:0] e_xnor);
      chk({name, ".valid"}, {31'd0, ov4}, {31'd0, ov});
      chk({name, ".and"},  {28'd0, and4},  {28'd0, e_and});
      chk({name, ".or"},   {28'd0, or4},   {28'd0, e_or});
      chk({name, ".nand"}, {28'd0, nand4}, {28'd0, e_nand});
      chk({name, ".nor"},  {28'd0, nor4},  {28'd0, e_nor});
      chk({name, ".not"},  {28'd0, not4},  {28'd0, e_not});
      chk({name, ".xor"},  {28'd0, xor4},  {28'd0, e_xor});
      chk({name, ".xnor"}, {28'd0, xnor4}, {28'd0, e_xnor});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b0, 1'b0, 7'b0011101};
      vt[1] = '{1'b0, 1'b1, 7'b0110110};
      vt[2] = '{1'b1, 1'b0, 7'b0110010};
      vt[3] = '{1'b1, 1'b1, 7'b1100001};

      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      v4 = 1'b0; a4 = 4'd0; b4 = 4'd0;

      // Power-on reset
      #2 rst = 1'b1;
      #1;
      chk("reset_w1", {24'd0, r1}, 32'd0);
      chk4("reset_w4", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
`ifdef LOGIC_GATES_PARITY_EN
      chk("reset_par", {30'd0, par1, par4}, 32'd0);
`endif
      @(negedge clk) rst = 1'b0;

      // Truth table, one cycle latency
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a1 = vt[i].a; b1 = vt[i].b; v1 = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("tt_a%0d_b%0d", vt[i].a, vt[i].b), {24'd0, r1}, {24'd0, 1'b1, vt[i].exp});
      end

      // Async reset mid-run with outputs at 1,1,0,0,0,0,1
      @(negedge clk);
      v1 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {24'd0, r1}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_idle", {24'd0, r1}, 32'd0);

      // First valid edge after release loads
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
      @(posedge clk); #1;
      chk("load_after_reset", {24'd0, r1}, {24'd0, 8'b10110010});

      // Hold: new operands ignored while in_valid is low
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; v1 = 1'b0;
      @(posedge clk); #1;
      chk("hold_1", {24'd0, r1}, {24'd0, 8'b00110010});
      @(posedge clk); #1;
      chk("hold_2", {24'd0, r1}, {24'd0, 8'b00110010});

      // Wide operands
      @(negedge clk);
      a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
      @(posedge clk); #1;
      chk4("w4_mix", 1'b1, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0011, 4'b0110, 4'b1001);
`ifdef LOGIC_GATES_PARITY_EN
      chk("w4_mix.parity", {31'd0, par4}, 32'd0);
`endif

      // Equal operands: xor all zeros, xnor all ones
      @(negedge clk);
      a4 = 4'b0101; b4 = 4'b0101;
      @(posedge clk); #1;
      chk4("w4_equal", 1'b1, 4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b1111);

      // Odd parity pattern
      @(negedge clk);
      a4 = 4'b0001; b4 = 4'b0000;
      @(posedge clk); #1;
      chk4("w4_odd", 1'b1, 4'b0000, 4'b0001, 4'b1111, 4'b1110, 4'b1110, 4'b0001, 4'b1110);
`ifdef LOGIC_GATES_PARITY_EN
      chk("w4_odd.parity", {31'd0, par4}, 32'd1);
`endif

      // Wide hold
      @(negedge clk);
      a4 = 4'b1111; b4 = 4'b0000; v4 = 1'b0;
      @(posedge clk); #1;
      chk4("w4_hold", 1'b0, 4'b0000, 4'b0001, 4'b1111, 4'b1110, 4'b1110, 4'b0001, 4'b1110);
`ifdef LOGIC_GATES_PARITY_EN
      chk("w4_hold.parity", {31'd0, par4}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
